key_pulse_sequencer: RTL and testbench

- Transmitter-side driver for the lock FSM's filtered key interface, which takes one-hot, single-cycle key pulses.
- Holds a loaded sequence of key indices and replays it as correctly spaced one-hot pulses.
- Then watches the lock status flags and reports the outcome.
- Used for automated password entry and on-board self-test; sits between a host/test controller and the lock FSM key input.

---
 rtl/key_seq_pkg.sv | 26 ++
 rtl/key_seq_buffer.sv | 55 +++++
 rtl/key_pulse_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_key_pulse_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_seq_pkg.sv
// Shared types and width helpers for the key pulse sequencer.
// Optional feature macro: KEY_SEQ_AUTO_RETRY_EN (see key_pulse_sequencer.sv).
package key_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    WAIT_RESP,
    DONE
  } seq_state_e;

  localparam int KEY_IDX_W = 2;
  localparam int NUM_KEYS  = 4;

  // Bits needed to hold any value in 0..max_val (never less than 1).
  function automatic int val_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Key index to one-hot lock FSM key vector.
  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [KEY_IDX_W-1:0] k);
    return NUM_KEYS'(1) << k;
  endfunction

endpackage

// File: rtl/key_seq_buffer.sv
// Key entry store: SEQ_LENGTH x 2-bit registers, fill count, append-only
// write port, synchronous clear and a combinational read port.
module key_seq_buffer
  import key_seq_pkg::*;
#(
  parameter  int SEQ_LENGTH = 8,
  localparam int CNT_W      = val_w(SEQ_LENGTH),
  localparam int IDX_W      = val_w(SEQ_LENGTH - 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic [KEY_IDX_W-1:0] i_wr_key,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic [KEY_IDX_W-1:0] o_rd_key,
  output logic [CNT_W-1:0]     o_count
);

  logic [SEQ_LENGTH-1:0][KEY_IDX_W-1:0] r_mem;
  logic [CNT_W-1:0]                     r_count;
  logic                                 w_wr;

  // Clear beats a simultaneous write; writes beyond capacity are dropped.
  assign w_wr = i_wr_en && !i_clear && (r_count < CNT_W'(SEQ_LENGTH));

  // Append the new entry at the current fill level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < SEQ_LENGTH; i++) begin
        if (w_wr && (r_count == CNT_W'(i))) r_mem[i] <= i_wr_key;
      end
    end
  end

  // Fill count: clear empties, each accepted write adds one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (w_wr)    r_count <= r_count + 1'b1;
  end

  // Read mux; an out-of-range index reads as key 0.
  always_comb begin
    o_rd_key = '0;
    for (int i = 0; i < SEQ_LENGTH; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rd_key = r_mem[i];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/key_pulse_sequencer.sv
// Replays a stored key sequence as spaced one-hot pulses to the lock FSM,
// then watches lock/error flags and reports the outcome.
// Optional: define KEY_SEQ_AUTO_RETRY_EN for one automatic replay after an
// error response (adds the o_retried output).
module key_pulse_sequencer
  import key_seq_pkg::*;
#(
  parameter int SEQ_LENGTH   = 8,
  parameter int GAP_CYCLES   = 4,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_load_valid,
  input  logic [KEY_IDX_W-1:0] i_load_key,
  output logic                 o_load_ready,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic [NUM_KEYS-1:0]  o_key_pulse,
  input  logic                 i_lock_flag,
  input  logic                 i_error_flag,
  output logic                 o_done,
  output logic                 o_result_changed,
  output logic                 o_result_error,
  output logic                 o_result_timeout
`ifdef KEY_SEQ_AUTO_RETRY_EN
  ,
  output logic                 o_retried
`endif
);

  localparam int CNT_W = val_w(SEQ_LENGTH);
  localparam int IDX_W = val_w(SEQ_LENGTH - 1);
  localparam int GAP_W = val_w(GAP_CYCLES - 1);
  localparam int TMR_W = val_w(RESP_TIMEOUT - 1);

  seq_state_e            r_state;
  logic [IDX_W-1:0]      r_index;
  logic [GAP_W-1:0]      r_gap;
  logic [TMR_W-1:0]      r_timer;
  logic                  r_lock_start;
  logic [NUM_KEYS-1:0]   r_key_pulse;
  logic                  r_done;
  logic                  r_res_chg;
  logic                  r_res_err;
  logic                  r_res_to;

  logic [CNT_W-1:0]      w_count;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [KEY_IDX_W-1:0]  w_rd_key;
  logic [KEY_IDX_W-1:0]  w_first_key;
  logic                  w_idle;
  logic                  w_clear;
  logic                  w_load_fire;
  logic                  w_start_ok;
  logic                  w_last_entry;
  logic                  w_replay;

`ifdef KEY_SEQ_AUTO_RETRY_EN
  logic                  r_replay;
  logic                  r_retried;
  assign w_replay  = r_replay;
  assign o_retried = r_retried;
`else
  assign w_replay  = 1'b0;
`endif

  assign w_idle       = (r_state == IDLE);
  assign o_load_ready = w_idle && (w_count < CNT_W'(SEQ_LENGTH));
  assign w_clear      = w_idle && i_clear;
  assign w_load_fire  = i_load_valid && o_load_ready;

  // Start sees the count after this cycle's load/clear: a load in the same
  // cycle makes an empty buffer startable, a clear makes any buffer empty.
  assign w_start_ok = w_idle && i_start && !i_clear && (w_load_fire || (w_count != '0));

  // Entry 0 is still being written when start coincides with the first load.
  assign w_first_key = (w_count == '0) ? i_load_key : w_rd_key;

  // Read address is the entry to send next: 0 at start/replay, else index+1.
  assign w_rd_idx     = (w_idle || w_replay) ? '0 : r_index + 1'b1;
  assign w_last_entry = ((CNT_W'(r_index) + 1'b1) == w_count);

  key_seq_buffer #(
    .SEQ_LENGTH (SEQ_LENGTH)
  ) u_buf (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_clear),
    .i_wr_en  (w_load_fire),
    .i_wr_key (i_load_key),
    .i_rd_idx (w_rd_idx),
    .o_rd_key (w_rd_key),
    .o_count  (w_count)
  );

  // Sequencer FSM with registered pulse, done and result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_gap        <= '0;
      r_timer      <= '0;
      r_lock_start <= 1'b0;
      r_key_pulse  <= '0;
      r_done       <= 1'b0;
      r_res_chg    <= 1'b0;
      r_res_err    <= 1'b0;
      r_res_to     <= 1'b0;
`ifdef KEY_SEQ_AUTO_RETRY_EN
      r_replay     <= 1'b0;
      r_retried    <= 1'b0;
`endif
    end else begin
      r_key_pulse <= '0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_lock_start <= i_lock_flag;
            r_res_chg    <= 1'b0;
            r_res_err    <= 1'b0;
            r_res_to     <= 1'b0;
            r_index      <= '0;
            r_key_pulse  <= key_onehot(w_first_key);
            r_state      <= SEND;
`ifdef KEY_SEQ_AUTO_RETRY_EN
            r_replay     <= 1'b0;
            r_retried    <= 1'b0;
`endif
          end
        end
        SEND: begin
          r_gap   <= GAP_W'(GAP_CYCLES - 1);
          r_state <= GAP;
        end
        GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (w_replay) begin
`ifdef KEY_SEQ_AUTO_RETRY_EN
            r_replay    <= 1'b0;
`endif
            r_index     <= '0;
            r_key_pulse <= key_onehot(w_rd_key);
            r_state     <= SEND;
          end else if (w_last_entry) begin
            r_timer <= '0;
            r_state <= WAIT_RESP;
          end else begin
            r_index     <= r_index + 1'b1;
            r_key_pulse <= key_onehot(w_rd_key);
            r_state     <= SEND;
          end
        end
        WAIT_RESP: begin
          if (i_error_flag) begin
`ifdef KEY_SEQ_AUTO_RETRY_EN
            if (!r_retried) begin
              // First error: idle one gap, then replay from entry 0.
              r_retried    <= 1'b1;
              r_replay     <= 1'b1;
              r_lock_start <= i_lock_flag;
              r_gap        <= GAP_W'(GAP_CYCLES - 1);
              r_state      <= GAP;
            end else begin
              r_res_err <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
`else
            r_res_err <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= DONE;
`endif
          end else if (i_lock_flag != r_lock_start) begin
            r_res_chg <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (r_timer == TMR_W'(RESP_TIMEOUT - 1)) begin
            r_res_to <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy           = !w_idle;
  assign o_key_pulse      = r_key_pulse;
  assign o_done           = r_done;
  assign o_result_changed = r_res_chg;
  assign o_result_error   = r_res_err;
  assign o_result_timeout = r_res_to;

endmodule

// File: tb/tb_key_pulse_sequencer.sv
// Self-checking bench for key_pulse_sequencer (default parameters).
// Cycle 0 of a run is the cycle in which start is driven; cycle n is the
// n-th clock period after the edge that samples it.
module tb_key_pulse_sequencer;

  localparam int SEQ_LENGTH = 8;
  localparam int GAP        = 4;
  localparam int TMO        = 16;
  localparam int MAXC       = 256;
  localparam int NEVER      = MAXC + 100;
`ifdef KEY_SEQ_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       load_valid = 1'b0;
  logic [1:0] load_key = 2'd0;
  logic       start = 1'b0;
  logic       lock_flag = 1'b0;
  logic       error_flag = 1'b0;
  logic       load_ready, busy, done, res_chg, res_err, res_to;
  logic [3:0] key_pulse;
`ifdef KEY_SEQ_AUTO_RETRY_EN
  logic       retried;
`endif

  key_pulse_sequencer #(
    .SEQ_LENGTH   (SEQ_LENGTH),
    .GAP_CYCLES   (GAP),
    .RESP_TIMEOUT (TMO)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_clear          (clear),
    .i_load_valid     (load_valid),
    .i_load_key       (load_key),
    .o_load_ready     (load_ready),
    .i_start          (start),
    .o_busy           (busy),
    .o_key_pulse      (key_pulse),
    .i_lock_flag      (lock_flag),
    .i_error_flag     (error_flag),
    .o_done           (done),
    .o_result_changed (res_chg),
    .o_result_error   (res_err),
    .o_result_timeout (res_to)
`ifdef KEY_SEQ_AUTO_RETRY_EN
    ,
    .o_retried        (retried)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- table-driven idle-mode vectors ----------------
  typedef struct {
    logic       clr;
    logic       lv;
    logic [1:0] key;
    logic       st;
    logic       exp_ready;
    logic       exp_busy;
    logic [3:0] exp_pulse;
  } vec_t;
  vec_t tbl[15];

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk); #1;
      clear = tbl[i].clr; load_valid = tbl[i].lv; load_key = tbl[i].key; start = tbl[i].st;
      @(negedge clk);
      check($sformatf("vec%0d {ready,busy,done,pulse}", i), {load_ready, busy, done, key_pulse},
            {tbl[i].exp_ready, tbl[i].exp_busy, 1'b0, tbl[i].exp_pulse});
    end
  endtask

  // ---------------- buffer helpers ----------------
  logic [1:0] ld[16];

  task automatic load_keys(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      load_valid = 1'b1; load_key = ld[i];
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic clear_buf();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  // ---------------- scenario + reference model ----------------
  int         sc_n;
  logic [1:0] sc_keys[SEQ_LENGTH];
  bit         sc_lock0;
  int         sc_err_s, sc_err_e, sc_lock_t;
  bit         sc_ls;
  logic [1:0] sc_ls_key;
  bit         sc_poke;

  logic [3:0] m_pulse[MAXC+1];
  bit         m_busy[MAXC+1];
  bit         m_done[MAXC+1];
  int         m_end;
  logic [2:0] m_res;
  bit         m_retr;
  logic [2:0] last_res = 3'b000;

  logic [3:0] obs_pulse[MAXC+1];
  int         obs_done_c;

  function automatic bit f_err(input int c);
    return (c >= sc_err_s) && (c < sc_err_e);
  endfunction

  function automatic bit f_lock(input int c);
    return sc_lock0 ^ (c >= sc_lock_t);
  endfunction

  // Outcome from the rules: pulses every GAP+1 cycles from cycle 1, then a
  // TMO-cycle response window scanned in priority order; done one cycle
  // after the deciding window cycle.
  task automatic build_model();
    int first;
    int c;
    bit lstart;
    bit retried;
    bit fin;
    int w0;
    int outc;
    first = 1; c = 0; lstart = f_lock(0); retried = 0; fin = 0;
    for (int k = 0; k <= MAXC; k++) begin
      m_pulse[k] = 4'd0; m_busy[k] = 0; m_done[k] = 0;
    end
    while (!fin) begin
      for (int i = 0; i < sc_n; i++) m_pulse[first + i * (GAP + 1)] = 4'd1 << sc_keys[i];
      w0 = first + sc_n * (GAP + 1);
      outc = 0;
      for (c = w0; c < w0 + TMO; c++) begin
        if (f_err(c)) begin outc = 1; break; end
        if (f_lock(c) != lstart) begin outc = 2; break; end
      end
      if (outc == 0) begin c = w0 + TMO - 1; outc = 3; end
      if (outc == 1 && RETRY_EN && !retried) begin
        retried = 1; lstart = f_lock(c); first = c + GAP + 1;
      end else begin
        fin = 1; m_end = c + 1;
        m_res = (outc == 1) ? 3'b010 : (outc == 2) ? 3'b100 : 3'b001;
      end
    end
    for (int k = 1; k <= m_end; k++) m_busy[k] = 1;
    m_done[m_end] = 1;
    m_retr = retried;
  endtask

  task automatic run_scn(input string tag);
    int         poke_c;
    logic [2:0] exp_res;
    build_model();
    poke_c = sc_poke ? int'($urandom_range(2, m_end - 1)) : -1;
    obs_done_c = -1;
    for (int c = 0; c <= m_end + 1; c++) begin
      @(posedge clk); #1;
      start      = (c == 0) || (c == poke_c);
      load_valid = (c == 0 && sc_ls) || (c == poke_c);
      load_key   = (c == 0) ? sc_ls_key : 2'd1;
      error_flag = f_err(c);
      lock_flag  = f_lock(c);
      @(negedge clk);
      obs_pulse[c] = key_pulse;
      if (done === 1'b1 && obs_done_c < 0) obs_done_c = c;
      exp_res = (c == 0) ? last_res : (c >= m_end) ? m_res : 3'b000;
      check($sformatf("%s c%0d {busy,done,pulse,res}", tag, c),
            {busy, done, key_pulse, res_chg, res_err, res_to},
            {m_busy[c], m_done[c], m_pulse[c], exp_res});
    end
`ifdef KEY_SEQ_AUTO_RETRY_EN
    check($sformatf("%s retried", tag), retried, m_retr);
`endif
    last_res = m_res;
    error_flag = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic set_keys4();
    ld[0] = 2'd3; ld[1] = 2'd1; ld[2] = 2'd0; ld[3] = 2'd2;
    sc_n = 4;
    for (int i = 0; i < 4; i++) sc_keys[i] = ld[i];
    sc_ls = 0; sc_ls_key = 2'd0; sc_poke = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: fill 8, ninth dropped, clear, empty start ignored, clear beats load.
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 1'b1, 2'(i), 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[12] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0};

    // Reset state.
    #3;
    check("reset {ready,busy,done,pulse,res}",
          {load_ready, busy, done, key_pulse, res_chg, res_err, res_to}, {3'b100, 4'd0, 3'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to capacity, ninth entry must be dropped: run plays exactly 8.
    apply_rows(0, 8);
    sc_n = 8;
    for (int i = 0; i < 8; i++) sc_keys[i] = 2'(i);
    sc_ls = 0; sc_ls_key = 2'd0; sc_poke = 0;
    sc_lock0 = lock_flag; sc_err_s = NEVER; sc_err_e = NEVER; sc_lock_t = NEVER;
    run_scn("full8");
    apply_rows(9, 14);

    // Asynchronous reset in the middle of a pulse.
    ld[0] = 2'd1; ld[1] = 2'd3;
    load_keys(2);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("pre-reset pulse", key_pulse, 4'b0010);
    #2 rst_n = 1'b0;
    #1 check("async reset {ready,busy,done,pulse}", {load_ready, busy, done, key_pulse}, {3'b100, 4'd0});
    @(posedge clk); #1; rst_n = 1'b1;
    last_res = 3'b000;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("post-reset count empty {busy,pulse}", {busy, key_pulse}, {1'b0, 4'd0});

    // Lock flag falls 3 cycles after the last pulse.
    set_keys4();
    load_keys(4);
    @(posedge clk); #1; lock_flag = 1'b1;
    sc_lock0 = 1'b1; sc_err_s = NEVER; sc_err_e = NEVER; sc_lock_t = 16 + 3;
    run_scn("lockfall");
    check("lockfall pulse c1", obs_pulse[1], 4'b1000);
    check("lockfall pulse c6", obs_pulse[6], 4'b0010);
    check("lockfall pulse c11", obs_pulse[11], 4'b0001);
    check("lockfall pulse c16", obs_pulse[16], 4'b0100);
    check("lockfall pulse c2 width", obs_pulse[2], 4'b0000);
    check("lockfall done cycle", obs_done_c, 22);
    check("lockfall results", {res_chg, res_err, res_to}, 3'b100);

    // Error held through the window while lock also toggles: error wins.
    sc_lock0 = lock_flag; sc_err_s = 21; sc_err_e = NEVER; sc_lock_t = 21;
    run_scn("errwin");
    check("errwin results", {res_chg, res_err, res_to}, 3'b010);

    // No response: timeout, then replay of the preserved buffer.
    sc_lock0 = lock_flag; sc_err_s = NEVER; sc_err_e = NEVER; sc_lock_t = NEVER;
    run_scn("timeout");
    check("timeout done cycle", obs_done_c, 1 + 4 * (GAP + 1) + TMO);
    check("timeout results", {res_chg, res_err, res_to}, 3'b001);
    run_scn("replay");
    check("replay pulse c1", obs_pulse[1], 4'b1000);
    check("replay pulse c16", obs_pulse[16], 4'b0100);

    // Start and first load in the same cycle on an empty buffer.
    clear_buf();
    sc_n = 1; sc_keys[0] = 2'd2; sc_ls = 1; sc_ls_key = 2'd2; sc_poke = 0;
    sc_lock0 = lock_flag; sc_err_s = NEVER; sc_err_e = NEVER; sc_lock_t = NEVER;
    run_scn("startload");
    check("startload pulse c1", obs_pulse[1], 4'b0100);

    // Randomized runs: fresh loads or replays, random flag timing,
    // stray start/load while busy.
    for (int it = 0; it < 12; it++) begin
      int w0;
      if (it % 3 != 2) begin
        int extra;
        clear_buf();
        sc_n = $urandom_range(1, SEQ_LENGTH);
        for (int i = 0; i < 16; i++) ld[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < sc_n; i++) sc_keys[i] = ld[i];
        extra = (sc_n == SEQ_LENGTH) ? 2 : 0;
        load_keys(sc_n + extra);
      end
      sc_ls = 0; sc_ls_key = 2'd0;
      sc_poke = $urandom_range(0, 1);
      w0 = 1 + sc_n * (GAP + 1);
      sc_lock0 = lock_flag;
      sc_err_s = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(1, w0 + TMO + 4));
      sc_err_e = sc_err_s + int'($urandom_range(1, 30));
      sc_lock_t = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(1, w0 + TMO + 4));
      run_scn($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
